// File: rtl/adder_pkg.sv
// Shared types and defaults for the word-serial wide adder.
// FSM state codes and default chunk geometry.
package adder_pkg;

  localparam int WIDTH_DEF = 2;
  localparam int WORDS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/wide_adder_seq_if.sv
// Start/done request bundle between requester and adder.
// The master drives operands and start; the slave returns the result.
interface wide_adder_seq_if
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int WORDS = WORDS_DEF
);

  localparam int OPW = WIDTH * WORDS;

  logic           i_start;
  logic [OPW-1:0] i_op_a;
  logic [OPW-1:0] i_op_b;
  logic           o_busy;
  logic           o_done;
  logic [OPW:0]   o_sum;

  modport master (
    output i_start, i_op_a, i_op_b,
    input  o_busy, o_done, o_sum
  );

  modport slave (
    input  i_start, i_op_a, i_op_b,
    output o_busy, o_done, o_sum
  );

endinterface

// File: rtl/nBitAdder.sv
// Narrow unsigned adder shared by the wide-add sequencer.
// Returns an N+1 bit sum; the MSB is the carry-out.
module nBitAdder #(
  parameter int N = 2
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/wide_adder_seq.sv
// Word-serial wide adder: one narrow adder, LSB chunk first,
// carry held in a register between chunks.
module wide_adder_seq
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input logic i_clk,
  input logic i_rst,
  wide_adder_seq_if.slave bus
);

  localparam int OPW = WIDTH * WORDS;
  localparam int IW  = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t         state;
  state_t         next;
  logic [OPW-1:0] a_q;
  logic [OPW-1:0] b_q;
  logic           carry;
  logic [IW-1:0]  idx;
  logic [OPW:0]   sum_q;

  logic [WIDTH-1:0] a_k;
  logic [WIDTH-1:0] b_k;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   inc_s;
  logic             cout;
  logic             last;
  logic             accept;
  logic             busy;
  logic             done;

  assign a_k = a_q[idx*WIDTH +: WIDTH];
  assign b_k = b_q[idx*WIDTH +: WIDTH];

  nBitAdder #(.N(WIDTH)) u_add (
    .a   (a_k),
    .b   (b_k),
    .sum (add_s)
  );

  // The two carries cannot both be set, so OR merges them.
  assign inc_s = {1'b0, add_s[WIDTH-1:0]}
               + {{WIDTH{1'b0}}, carry};
  assign cout  = add_s[WIDTH] | inc_s[WIDTH];
  assign last  = (idx == IW'(WORDS - 1));

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= next;
  end

  // Next-state and status decode.
  always_comb begin
    next   = state;
    busy   = 1'b0;
    done   = 1'b0;
    accept = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.i_start) begin
          accept = 1'b1;
          next   = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last) next = ST_DONE;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
        next = ST_IDLE;
      end
      default: next = ST_IDLE;
    endcase
  end

  // Operand capture and per-chunk accumulate.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum_q <= '0;
    end else if (accept) begin
      a_q   <= bus.i_op_a;
      b_q   <= bus.i_op_b;
      carry <= 1'b0;
      idx   <= '0;
      sum_q <= '0;
    end else if (state == ST_RUN) begin
      sum_q[idx*WIDTH +: WIDTH] <= inc_s[WIDTH-1:0];
      carry <= cout;
      if (last) sum_q[OPW] <= cout;
      else      idx <= idx + 1'b1;
    end
  end

  assign bus.o_busy = busy;
  assign bus.o_done = done;
  assign bus.o_sum  = sum_q;

endmodule

// File: tb/tb_wide_adder_seq.sv
// Directed self-checking bench for wide_adder_seq.
// Covers WORDS=4 and a WORDS=1 build.
module tb_wide_adder_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  wide_adder_seq_if #(.WIDTH(2), .WORDS(4)) bus4 ();
  wide_adder_seq_if #(.WIDTH(2), .WORDS(1)) bus1 ();

  wide_adder_seq #(.WIDTH(2), .WORDS(4)) dut4 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus4)
  );

  wide_adder_seq #(.WIDTH(2), .WORDS(1)) dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1)
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st4(input string tag, input logic b,
                     input logic d);
    chk({tag, "_busy"}, 16'(bus4.o_busy), 16'(b));
    chk({tag, "_done"}, 16'(bus4.o_done), 16'(d));
  endtask

  // Start, then expect 4 RUN cycles, DONE, then IDLE.
  task automatic add4(input string tag, input logic [7:0] a,
                      input logic [7:0] b, input logic [8:0] s);
    bus4.i_start = 1'b1;
    bus4.i_op_a  = a;
    bus4.i_op_b  = b;
    tick();
    bus4.i_start = 1'b0;
    bus4.i_op_a  = ~a;
    bus4.i_op_b  = ~b;
    for (int i = 1; i <= 4; i++) begin
      st4({tag, "_run"}, 1'b1, 1'b0);
      tick();
    end
    st4({tag, "_fin"}, 1'b1, 1'b1);
    chk({tag, "_sum"}, 16'(bus4.o_sum), 16'(s));
    tick();
    st4({tag, "_idle"}, 1'b0, 1'b0);
    chk({tag, "_hold"}, 16'(bus4.o_sum), 16'(s));
  endtask

  initial begin
    bus4.i_start = 1'b0;
    bus4.i_op_a  = '0;
    bus4.i_op_b  = '0;
    bus1.i_start = 1'b0;
    bus1.i_op_a  = '0;
    bus1.i_op_b  = '0;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    st4("reset", 1'b0, 1'b0);
    chk("reset_sum", 16'(bus4.o_sum), 16'h000);

    add4("b0001", 8'h00, 8'h01, 9'h001);
    add4("bff01", 8'hFF, 8'h01, 9'h100);
    add4("bffff", 8'hFF, 8'hFF, 9'h1FE);
    add4("ba55a", 8'hA5, 8'h5A, 9'h0FF);

    // Starts during RUN and DONE are dropped; a held start
    // is taken once the FSM is back in IDLE.
    bus4.i_start = 1'b1;
    bus4.i_op_a  = 8'h12;
    bus4.i_op_b  = 8'h34;
    tick();
    bus4.i_start = 1'b0;
    tick();
    bus4.i_start = 1'b1;
    bus4.i_op_a  = 8'h11;
    bus4.i_op_b  = 8'h11;
    tick();
    bus4.i_start = 1'b0;
    tick();
    tick();
    st4("busy_fin", 1'b1, 1'b1);
    chk("busy_sum", 16'(bus4.o_sum), 16'h046);
    bus4.i_start = 1'b1;
    tick();
    st4("held_idle", 1'b0, 1'b0);
    chk("held_keep", 16'(bus4.o_sum), 16'h046);
    tick();
    bus4.i_start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      st4("held_run", 1'b1, 1'b0);
      tick();
    end
    st4("held_fin", 1'b1, 1'b1);
    chk("held_sum", 16'(bus4.o_sum), 16'h022);
    tick();

    // Asynchronous abort after two RUN cycles.
    bus4.i_start = 1'b1;
    bus4.i_op_a  = 8'h55;
    bus4.i_op_b  = 8'h55;
    tick();
    bus4.i_start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    st4("abort", 1'b0, 1'b0);
    chk("abort_sum", 16'(bus4.o_sum), 16'h000);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      st4("abort_quiet", 1'b0, 1'b0);
      tick();
    end
    add4("b0303", 8'h03, 8'h03, 9'h006);

    // Single-chunk build.
    bus1.i_start = 1'b1;
    bus1.i_op_a  = 2'b11;
    bus1.i_op_b  = 2'b11;
    tick();
    bus1.i_start = 1'b0;
    bus1.i_op_a  = 2'b00;
    bus1.i_op_b  = 2'b00;
    chk("w1_busy", 16'(bus1.o_busy), 16'h1);
    chk("w1_run", 16'(bus1.o_done), 16'h0);
    tick();
    chk("w1_done", 16'(bus1.o_done), 16'h1);
    chk("w1_sum", 16'(bus1.o_sum), 16'h006);
    tick();
    chk("w1_idle", 16'(bus1.o_busy), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wide_adder_seq.md
# wide_adder_seq

Word-serial wide-operand adder controller. It sequences one narrow `WIDTH`-bit adder over `WORDS` chunks, least-significant chunk first, and carries between chunks in a register. This lets the team add `WIDTH*WORDS`-bit operands without instantiating a wide combinational adder. It sits between a requester using a start/done handshake and the shared narrow adder datapath.

## Interface
Parameters:
- `WIDTH`, 2, chunk width; equals the width of the narrow adder it drives.
- `WORDS`, 4, number of chunks; legal range is ≥1. Full operand width is `OPW = WIDTH*WORDS`.

Ports:
- `i_clk`  in  1  single clock; all state changes on the rising edge.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_start`  in  1  request; sampled only in IDLE.
- `i_op_a`  in  OPW  operand A; captured on an accepted start.
- `i_op_b`  in  OPW  operand B; captured on an accepted start.
- `o_busy`  out  1  high in RUN and DONE.
- `o_done`  out  1  one-cycle pulse; `o_sum` is final while it is high.
- `o_sum`  out  OPW+1  result; MSB is the final carry-out.

## Operation
- States: IDLE, RUN, DONE. Encoding is 2 bits.
- IDLE:
  - `o_busy`=0.
  - On `i_start`=1: capture A and B into internal registers, clear carry, set chunk index `idx`=0, clear `o_sum` to 0, go to RUN.
- RUN: each cycle processes chunk k=`idx`.
  - Compute s = A[k] + B[k] + carry, a `WIDTH+1`-bit result.
  - Write `o_sum[k*WIDTH +: WIDTH]` = s[WIDTH-1:0] and carry = s[WIDTH].
  - If `idx`==WORDS-1: also write `o_sum[OPW]` = s[WIDTH], then go to DONE. Otherwise `idx`++.
- DONE: `o_done`=1 for exactly one cycle, then go to IDLE.
- `o_sum` holds its value in IDLE until the next accepted start.
- `i_start` in RUN or DONE is ignored; it is not queued.
- Input operands may change freely after capture. Only the captured copies are used.
- Arithmetic is unsigned; there is no overflow beyond `o_sum[OPW]`. `idx` width is `max(1,$clog2(WORDS))`.

## Timing
- Reset value of every output is 0: `o_busy`=0, `o_done`=0, `o_sum`=0. State=IDLE, carry=0, `idx`=0.
- Start accepted at edge E0. RUN occupies the cycles after E0..E(WORDS-1). `o_done` is high in the cycle after edge E(WORDS).
- Total latency from accepting edge to `o_done` high is WORDS+1 cycles. The earliest next start is accepted at the edge ending the `o_done` cycle +1, i.e. when state is IDLE.
- Intermediate `o_sum` chunks update one per cycle and are not valid until `o_done`.
- Reset mid-operation: immediate (asynchronous) return to IDLE with all registers 0. No `o_done` is produced for the aborted add.
- WORDS=1: one RUN cycle; `o_sum` = A+B in full, with `o_done` 2 cycles after the start edge.
- Carry ripple: the carry propagates one chunk per cycle. The all-ones + 1 case needs no extra cycles.

## Structure
- Shared package `adder_pkg`:
  - FSM state constants `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2.
  - Default `WIDTH`/`WORDS`.
- Sub-module: one instance of the team's `nBitAdder` (width `WIDTH`) computes A[k]+B[k].
- The carry-in is added to that `WIDTH+1`-bit result inline. The final chunk carry is the OR of the adder carry and the increment carry; these two are mutually exclusive.
- The controller, operand registers, carry and index are all in `wide_adder_seq`.

## Test plan
All scenarios use WIDTH=2, WORDS=4 (8-bit operands, 9-bit sum) unless noted.
- Reset then idle: `i_rst` pulse, no start → `o_busy`=0, `o_done`=0, `o_sum`=9'h000.
- Basic add, `i_op_a`=8'h00, `i_op_b`=8'h01, `i_start` 1 cycle → `o_busy` for 5 cycles, `o_done` pulse 5 cycles after the start edge, `o_sum`=9'h001.
- Full ripple: 8'hFF+8'h01 → 9'h100. 8'hFF+8'hFF → 9'h1FE. 8'hA5+8'h5A → 9'h0FF.
- Start while busy: second `i_start` with 8'h11+8'h11 during RUN and during DONE → ignored, `o_sum` stays the first result. A start held high into IDLE is accepted the next cycle.
- Reset mid-operation: assert `i_rst` after 2 RUN cycles → outputs 0 immediately, no `o_done`. A fresh start of 8'h03+8'h03 afterwards gives 9'h006.
- WORDS=1 build, `i_op_a`=2'b11, `i_op_b`=2'b11 → `o_sum`=3'b110, `o_done` 2 cycles after the start edge.
